// File: rtl/axi_rd_arbiter.sv
// ============================================================================
// Module      : axi_rd_arbiter
// Description : Two-master, one-slave AXI4 read arbiter (AR and R channels).
//               M0 (display scanout) has fixed priority over M1 (blitter/DMA).
//               A starvation counter forces M1 to win after STARVE_LIMIT
//               consecutive lost rounds. One burst is outstanding at a time,
//               and the grant is held from AR acceptance to the final R beat.
// Ports       : clk, rst                      - clock, sync active-high reset
//               m0_ar*/m1_ar* (in), mN_arready - master read address channels
//               m0_r*/m1_r* (out), mN_rready   - master read data channels
//               s_ar* (out), s_arready         - slave read address channel
//               s_r* (in), s_rready            - slave read data channel
//               grant                          - current / last granted master
//               busy                           - a burst is in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_rd_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_araddr,
  input  logic [7:0]  m0_arlen,
  input  logic [2:0]  m0_arsize,
  input  logic [1:0]  m0_arburst,
  input  logic        m0_arvalid,
  output logic        m0_arready,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rlast,
  output logic        m0_rvalid,
  input  logic        m0_rready,

  input  logic [31:0] m1_araddr,
  input  logic [7:0]  m1_arlen,
  input  logic [2:0]  m1_arsize,
  input  logic [1:0]  m1_arburst,
  input  logic        m1_arvalid,
  output logic        m1_arready,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rlast,
  output logic        m1_rvalid,
  input  logic        m1_rready,

  output logic [31:0] s_araddr,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  output logic        s_arvalid,
  input  logic        s_arready,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rlast,
  input  logic        s_rvalid,
  output logic        s_rready,

  output logic        grant,
  output logic        busy
);

  localparam logic [7:0] C_STARVE_LIMIT = 8'(STARVE_LIMIT);
  localparam logic [7:0] C_CTR_MAX      = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_grant;
  logic       w_grant_nxt;
  logic [7:0] r_starve_ctr;
  logic [7:0] w_starve_ctr_nxt;

  logic       w_m1_wins;
  logic       w_gnt_arvalid;
  logic       w_gnt_rready;

  // M1 wins when it is alone, or when it has lost STARVE_LIMIT rounds in a row.
  assign w_m1_wins = m1_arvalid & (~m0_arvalid | (r_starve_ctr == C_STARVE_LIMIT));

  assign w_gnt_arvalid = r_grant ? m1_arvalid : m0_arvalid;
  assign w_gnt_rready  = r_grant ? m1_rready  : m0_rready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= 1'b0;
      r_starve_ctr <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_starve_ctr <= w_starve_ctr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake gating
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_starve_ctr_nxt = r_starve_ctr;
    s_arvalid        = 1'b0;
    s_rready         = 1'b0;
    m0_arready       = 1'b0;
    m1_arready       = 1'b0;
    m0_rvalid        = 1'b0;
    m1_rvalid        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Arbitration is the only point at which grant and the counter move.
        if (m0_arvalid | m1_arvalid) begin
          w_grant_nxt = w_m1_wins;
          w_state_nxt = ST_ADDR;
          if (w_m1_wins) begin
            w_starve_ctr_nxt = 8'd0;
          end else if (m1_arvalid && (r_starve_ctr != C_CTR_MAX)) begin
            w_starve_ctr_nxt = r_starve_ctr + 8'd1;
          end
        end
      end

      ST_ADDR: begin
        s_arvalid = w_gnt_arvalid;
        if (r_grant) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
        if (w_gnt_arvalid && s_arready) begin
          w_state_nxt = ST_DATA;
        end
      end

      ST_DATA: begin
        s_rready = w_gnt_rready;
        if (r_grant) begin
          m1_rvalid = s_rvalid;
        end else begin
          m0_rvalid = s_rvalid;
        end
        if (s_rvalid && w_gnt_rready && s_rlast) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Address mux follows the registered grant; outside ADDR the values are
  // don't-care because s_arvalid is low.
  // --------------------------------------------------------------------------
  assign s_araddr  = r_grant ? m1_araddr  : m0_araddr;
  assign s_arlen   = r_grant ? m1_arlen   : m0_arlen;
  assign s_arsize  = r_grant ? m1_arsize  : m0_arsize;
  assign s_arburst = r_grant ? m1_arburst : m0_arburst;

  // Read payload is broadcast; only rvalid is steered to the owner.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

  assign grant = r_grant;
  assign busy  = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
// ============================================================================
// Module      : tb_axi_rd_arbiter
// Description : Self-checking bench for axi_rd_arbiter. Bench-side masters and
//               a slave generate randomized traffic; a transaction-level model
//               of the arbitration rules predicts every visible output.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axi_rd_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [31:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid, s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid, s_rready;
  logic        grant, busy;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant), .busy(busy)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, act, exp);
    end
  endtask

  // ---------------- traffic configuration ----------------
  int req_pct [2];
  int len_fix [2];   // -1 selects a random length (including 0 and 255)
  int arready_pct, rvalid_pct, rready_pct;

  // ---------------- bench masters ----------------
  bit          pend   [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_len  [2];
  logic [2:0]  p_size [2];
  logic [1:0]  p_burst[2];

  // ---------------- bench slave ----------------
  int          q_len[$];
  int          cur_beat;
  bit          beat_hold;
  logic [31:0] b_data;
  logic [1:0]  b_resp;
  bit          b_last;

  // ---------------- reference model (transaction level) ----------------
  // free  : no burst owns the slave port
  // data  : owner's address has been accepted, beats are flowing
  bit   mdl_free, mdl_data;
  int   mdl_owner, mdl_ctr, mdl_len, mdl_got;
  int   arb_log[$];
  int   rlast_cyc[$];

  function automatic logic arv(input int n);
    return (n == 1) ? m1_arvalid : m0_arvalid;
  endfunction

  function automatic logic rrd(input int n);
    return (n == 1) ? m1_rready : m0_rready;
  endfunction

  task automatic model_reset();
    mdl_free  = 1'b1;
    mdl_data  = 1'b0;
    mdl_owner = 0;
    mdl_ctr   = 0;
    mdl_got   = 0;
    arb_log.delete();
    q_len.delete();
    cur_beat  = 0;
    beat_hold = 1'b0;
    pend[0]   = 1'b0;
    pend[1]   = 1'b0;
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < 2; n++) begin
      if (!pend[n] && ($urandom_range(99) < req_pct[n])) begin
        pend[n]    = 1'b1;
        p_addr[n]  = $urandom;
        p_size[n]  = 3'($urandom_range(2));
        p_burst[n] = 2'($urandom_range(2));
        if (len_fix[n] >= 0) p_len[n] = 8'(len_fix[n]);
        else begin
          case ($urandom_range(3))
            0:       p_len[n] = 8'd0;
            1:       p_len[n] = 8'd255;
            default: p_len[n] = 8'($urandom_range(15));
          endcase
        end
      end
    end
    m0_arvalid = pend[0]; m0_araddr = p_addr[0]; m0_arlen = p_len[0];
    m0_arsize  = p_size[0]; m0_arburst = p_burst[0];
    m1_arvalid = pend[1]; m1_araddr = p_addr[1]; m1_arlen = p_len[1];
    m1_arsize  = p_size[1]; m1_arburst = p_burst[1];
    m0_rready  = ($urandom_range(99) < rready_pct);
    m1_rready  = ($urandom_range(99) < rready_pct);

    s_arready = ($urandom_range(99) < arready_pct);
    if (!beat_hold && (q_len.size() > 0) && ($urandom_range(99) < rvalid_pct)) begin
      beat_hold = 1'b1;
      b_data    = $urandom;
      b_resp    = 2'($urandom_range(3));
      b_last    = (cur_beat == q_len[0]);
    end
    s_rvalid = beat_hold;
    s_rdata  = beat_hold ? b_data : $urandom;
    s_rresp  = beat_hold ? b_resp : 2'd0;
    s_rlast  = beat_hold ? b_last : 1'b0;
  endtask

  task automatic check_outputs();
    logic e_ar0, e_ar1, e_rv0, e_rv1, e_sarv, e_srr;
    e_ar0 = 0; e_ar1 = 0; e_rv0 = 0; e_rv1 = 0; e_sarv = 0; e_srr = 0;
    if (!mdl_free && !mdl_data) begin
      e_sarv = arv(mdl_owner);
      if (mdl_owner == 1) e_ar1 = s_arready; else e_ar0 = s_arready;
    end
    if (mdl_data) begin
      e_srr = rrd(mdl_owner);
      if (mdl_owner == 1) e_rv1 = s_rvalid; else e_rv0 = s_rvalid;
    end
    check_value("busy",       busy,       !mdl_free);
    check_value("grant",      grant,      mdl_owner[0]);
    check_value("s_arvalid",  s_arvalid,  e_sarv);
    check_value("s_rready",   s_rready,   e_srr);
    check_value("m0_arready", m0_arready, e_ar0);
    check_value("m1_arready", m1_arready, e_ar1);
    check_value("m0_rvalid",  m0_rvalid,  e_rv0);
    check_value("m1_rvalid",  m1_rvalid,  e_rv1);
    if (e_sarv) begin
      check_value("s_araddr",  s_araddr,  p_addr[mdl_owner]);
      check_value("s_arlen",   s_arlen,   p_len[mdl_owner]);
      check_value("s_arsize",  s_arsize,  p_size[mdl_owner]);
      check_value("s_arburst", s_arburst, p_burst[mdl_owner]);
    end
    if (beat_hold) begin
      check_value("m0_rdata", m0_rdata, b_data);
      check_value("m1_rdata", m1_rdata, b_data);
      check_value("m0_rresp", m0_rresp, b_resp);
      check_value("m1_rlast", m1_rlast, b_last);
    end
  endtask

  task automatic update_model();
    int w;
    if (mdl_free) begin
      if (m0_arvalid || m1_arvalid) begin
        w = (m1_arvalid && (!m0_arvalid || mdl_ctr == STARVE_LIMIT)) ? 1 : 0;
        if (w == 1) mdl_ctr = 0;
        else if (m1_arvalid && mdl_ctr < 255) mdl_ctr++;
        mdl_owner = w;
        mdl_len   = p_len[w] + 1;
        mdl_got   = 0;
        mdl_free  = 1'b0;
        arb_log.push_back(w);
      end
    end else if (!mdl_data) begin
      if (arv(mdl_owner) && s_arready) mdl_data = 1'b1;
    end else if (beat_hold && rrd(mdl_owner)) begin
      mdl_got++;
      if (b_last) begin
        check_value("beat_count", mdl_got, mdl_len);
        mdl_free = 1'b1;
        mdl_data = 1'b0;
        rlast_cyc.push_back(cyc);
      end
    end
    // Bench slave and masters react to what the DUT actually drives.
    if (s_arvalid && s_arready) q_len.push_back(int'(s_arlen));
    if (beat_hold && s_rready) begin
      beat_hold = 1'b0;
      if (b_last) begin
        void'(q_len.pop_front());
        cur_beat = 0;
      end else cur_beat++;
    end
    if (pend[0] && m0_arready) pend[0] = 1'b0;
    if (pend[1] && m1_arready) pend[1] = 1'b0;
  endtask

  task automatic step(input bit do_rst);
    @(negedge clk);
    rst = do_rst;
    drive_inputs();
    #1;
    if (do_rst) model_reset();
    else begin
      check_outputs();
      update_model();
    end
    cyc++;
  endtask

  task automatic set_cfg(input int r0, input int r1, input int l0, input int l1,
                         input int arp, input int rvp, input int rrp);
    req_pct[0] = r0; req_pct[1] = r1; len_fix[0] = l0; len_fix[1] = l1;
    arready_pct = arp; rvalid_pct = rvp; rready_pct = rrp;
  endtask

  // Reset, then both masters request continuously: M1 must win every fifth round.
  task automatic grant_sequence();
    int n;
    set_cfg(100, 100, 0, 0, 100, 100, 100);
    step(1);
    for (int i = 0; i < 300 && arb_log.size() < 10; i++) step(0);
    check_value("grant_seq_timeout", arb_log.size() >= 10, 1'b1);
    n = (arb_log.size() < 10) ? arb_log.size() : 10;
    for (int i = 0; i < n; i++)
      check_value($sformatf("grant_seq[%0d]", i), arb_log[i], (i % 5 == 4) ? 1 : 0);
  endtask

  initial begin
    int base, k;
    rst = 1'b1;
    m0_arvalid = 0; m1_arvalid = 0; m0_rready = 0; m1_rready = 0;
    s_arready = 0; s_rvalid = 0; s_rlast = 0; s_rdata = 0; s_rresp = 0;
    m0_araddr = 0; m1_araddr = 0; m0_arlen = 0; m1_arlen = 0;
    m0_arsize = 0; m1_arsize = 0; m0_arburst = 0; m1_arburst = 0;
    p_addr[0] = 0; p_addr[1] = 0; p_len[0] = 0; p_len[1] = 0;
    p_size[0] = 0; p_size[1] = 0; p_burst[0] = 0; p_burst[1] = 0;
    set_cfg(0, 0, 0, 0, 100, 100, 100);
    model_reset();
    rlast_cyc.delete();

    // Reset state
    step(1); step(1);
    for (int i = 0; i < 3; i++) step(0);

    // M0 alone, 32-beat bursts
    set_cfg(100, 0, 31, 0, 100, 100, 100);
    for (int i = 0; i < 120; i++) step(0);
    set_cfg(0, 0, 31, 0, 100, 100, 100);
    for (int i = 0; i < 40; i++) step(0);

    // Fixed priority with starvation guard
    grant_sequence();

    // M0 asserts while M1 is at beat 3 of 16: no preemption, M0 next
    set_cfg(0, 100, 0, 15, 100, 100, 100);
    step(1);
    for (int i = 0; i < 100 && !(mdl_owner == 1 && mdl_data && mdl_got == 3); i++) step(0);
    check_value("m1_beat3_timeout", (mdl_owner == 1 && mdl_data && mdl_got == 3), 1'b1);
    base = arb_log.size();
    set_cfg(100, 0, 3, 15, 100, 100, 100);
    for (int i = 0; i < 100 && arb_log.size() == base; i++) step(0);
    check_value("m0_after_m1", (arb_log.size() > base) ? arb_log[base] : 9, 0);

    // Address stall then master backpressure
    set_cfg(100, 0, 7, 0, 0, 100, 50);
    for (int i = 0; i < 12; i++) step(0);
    set_cfg(100, 0, 7, 0, 100, 100, 50);
    for (int i = 0; i < 100; i++) step(0);

    // Mixed random traffic including 256-beat bursts
    set_cfg(40, 60, -1, -1, 70, 70, 70);
    for (int i = 0; i < 4000; i++) step(0);
    set_cfg(90, 90, -1, -1, 90, 40, 90);
    for (int i = 0; i < 3000; i++) step(0);

    // Reset at beat 5 of an 8-beat M1 burst
    set_cfg(0, 100, 0, 7, 100, 100, 100);
    step(1);
    for (int i = 0; i < 100 && !(mdl_owner == 1 && mdl_data && mdl_got == 5); i++) step(0);
    check_value("m1_beat5_timeout", (mdl_owner == 1 && mdl_data && mdl_got == 5), 1'b1);
    step(1);
    set_cfg(0, 0, 0, 7, 100, 100, 100);
    step(0);
    check_value("rst_busy",  busy,  1'b0);
    check_value("rst_grant", grant, 1'b0);

    // Build up the starvation counter, then reset mid-burst: the next
    // sequence must start from a cleared counter.
    set_cfg(100, 100, 3, 3, 100, 100, 100);
    step(1);
    for (int i = 0; i < 100 && arb_log.size() < 3; i++) step(0);
    check_value("starve_build_timeout", arb_log.size() >= 3, 1'b1);
    grant_sequence();

    // Back-to-back single-beat M1 bursts: one burst every 3 cycles
    set_cfg(0, 100, 0, 0, 100, 100, 100);
    step(1);
    for (int i = 0; i < 10; i++) step(0);
    base = rlast_cyc.size();
    for (int i = 0; i < 30; i++) step(0);
    check_value("throughput", rlast_cyc.size() - base, 10);
    k = rlast_cyc.size();
    if (k >= 2) check_value("burst_period", rlast_cyc[k-1] - rlast_cyc[k-2], 3);
    else check_value("burst_period_count", k, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
